// File: rtl/mmio_host_sequencer_pkg.sv
// mmio_host_sequencer_pkg: MMIO widths, host sequencer state and command types.
package mmio_host_sequencer_pkg;
  localparam int TIA_MMIO_INDEX_WIDTH = 8;
  localparam int TIA_MMIO_DATA_WIDTH  = 32;
  typedef enum logic [1:0] {IDLE, READ_REQ, WRITE_REQ, RESPOND} mmio_host_state_t;
  typedef struct packed {
    logic                            write;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] index;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  data;
  } mmio_command_t;
endpackage

// File: rtl/mmio_if.sv
// mmio_if: request/acknowledge MMIO link between a host and a device.
interface mmio_if;
  import mmio_host_sequencer_pkg::*;
  logic                            read_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
  logic                            read_ack;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
  logic                            write_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
  logic                            write_ack;
  modport host (output read_req, read_index, write_req, write_index, write_data,
                input  read_ack, read_data, write_ack);
  modport device (input  read_req, read_index, write_req, write_index, write_data,
                  output read_ack, read_data, write_ack);
endinterface

// File: rtl/mmio_host_sequencer.sv
// mmio_host_sequencer: single-outstanding MMIO initiator with per-transaction timeout.
module mmio_host_sequencer
  import mmio_host_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [TIA_MMIO_INDEX_WIDTH-1:0] cmd_index,
  input  logic [TIA_MMIO_DATA_WIDTH-1:0]  cmd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [TIA_MMIO_DATA_WIDTH-1:0]  rsp_data,
  output logic                            rsp_timeout,
  output logic                            busy,
  mmio_if.host                            device_interface
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  mmio_host_state_t                r_state;
  mmio_command_t                   r_cmd;
  logic [CW-1:0]                   r_cnt;
  logic                            r_cmd_ready, r_busy, r_read_req, r_write_req;
  logic                            r_rsp_valid, r_rsp_write, r_rsp_timeout;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  r_rsp_data;
  logic                            w_ack, w_timeout;
  logic [CW-1:0]                   w_cnt_next;
  assign w_ack      = (r_state == READ_REQ) ? device_interface.read_ack : device_interface.write_ack;
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CW'(TIMEOUT_CYCLES));
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_read_req    <= 1'b0;
      r_write_req   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd       <= '{write: cmd_write, index: cmd_index, data: cmd_data};
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_read_req  <= !cmd_write;
            r_write_req <= cmd_write;
            r_state     <= cmd_write ? WRITE_REQ : READ_REQ;
          end
        end
        READ_REQ, WRITE_REQ: begin
          // an ack in the expiry cycle still completes the transaction normally
          if (w_ack || w_timeout) begin
            r_read_req    <= 1'b0;
            r_write_req   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_cmd.write;
            r_rsp_timeout <= !w_ack;
            r_rsp_data    <= (w_ack && !r_cmd.write) ? device_interface.read_data : '0;
            r_state       <= RESPOND;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign cmd_ready                    = r_cmd_ready;
  assign busy                         = r_busy;
  assign rsp_valid                    = r_rsp_valid;
  assign rsp_write                    = r_rsp_write;
  assign rsp_data                     = r_rsp_data;
  assign rsp_timeout                  = r_rsp_timeout;
  assign device_interface.read_req    = r_read_req;
  assign device_interface.write_req   = r_write_req;
  assign device_interface.read_index  = r_cmd.index;
  assign device_interface.write_index = r_cmd.index;
  assign device_interface.write_data  = r_cmd.data;
endmodule
